count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 155 +++++++++++++++
 tb/tb_count_monitor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// count_monitor: watches an external up-counter and its enable, locks once the
// counter has behaved for LOCK_COUNT consecutive edges, and flags/counts
// misbehaviour while locked.
//
// Optional feature: define COUNT_MONITOR_WRAP_EN to enable wrap_pulse
// generation; otherwise wrap_pulse is tied low.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   enable     enable of the observed counter
//   count_in   observed counter value (WIDTH bits)
//   clear_err  synchronous clear of err_cnt
//   locked     high while in TRACK
//   mismatch   one-cycle pulse after a bad transition in TRACK
//   err_cnt    saturating mismatch count (ERR_W bits)
//   expected   value count_in must take at the next edge
//   wrap_pulse one-cycle pulse after a verified all-ones to zero transition
module count_monitor #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] expected,
  output logic             wrap_pulse
);

  localparam int unsigned GOOD_W = 4;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [WIDTH-1:0]   prev_count_q, prev_count_d;
  logic               prev_en_q, prev_en_d;
  logic               mismatch_q, mismatch_d;
  logic               locked_q, locked_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [WIDTH-1:0]   expected_c;
  logic               correct_c;

  // Expected value is a pure function of the history flops.
  assign expected_c = prev_count_q + WIDTH'(prev_en_q);
  assign correct_c  = (count_in == expected_c);

  // Next-state, lock counting and error accounting.
  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    mismatch_d   = 1'b0;
    err_d        = err_q;
    prev_count_d = count_in;
    prev_en_d    = enable;

    case (state_q)
      IDLE: begin
        state_d = SYNC;
        good_d  = '0;
      end
      SYNC: begin
        if (correct_c) begin
          if (32'(good_q) + 32'd1 >= LOCK_COUNT) begin
            state_d = TRACK;
            good_d  = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end else begin
          good_d = '0;
        end
      end
      TRACK: begin
        if (!correct_c) begin
          mismatch_d = 1'b1;
          state_d    = SYNC;
          good_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase

    // A clear that coincides with a mismatch still records that mismatch.
    if (clear_err) begin
      err_d = mismatch_d ? ERR_W'(1) : '0;
    end else if (mismatch_d && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_W'(1);
    end

    locked_d = (state_d == TRACK);
  end

  // State and history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      good_q       <= '0;
      prev_count_q <= '0;
      prev_en_q    <= 1'b0;
      mismatch_q   <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      prev_count_q <= prev_count_d;
      prev_en_q    <= prev_en_d;
      mismatch_q   <= mismatch_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

`ifdef COUNT_MONITOR_WRAP_EN
  logic wrap_q, wrap_d;

  // Correct incrementing transition out of all-ones while tracking.
  always_comb begin
    wrap_d = (state_q == TRACK) && correct_c && prev_en_q && (prev_count_q == '1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_pulse = wrap_q;
`else
  assign wrap_pulse = 1'b0;
`endif

  assign locked   = locked_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_q;
  assign expected = expected_c;

endmodule

// File: tb/tb_count_monitor.sv
// Directed testbench for count_monitor (default parameters).
module tb_count_monitor;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] count_in;
  logic       clear_err;
  logic       locked;
  logic       mismatch;
  logic [7:0] err_cnt;
  logic [3:0] expected;
  logic       wrap_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] cnt;
  int mm_seen  = 0;

`ifdef COUNT_MONITOR_WRAP_EN
  localparam int WRAP_EXP = 1;
`else
  localparam int WRAP_EXP = 0;
`endif

  count_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .count_in   (count_in),
    .clear_err  (clear_err),
    .locked     (locked),
    .mismatch   (mismatch),
    .err_cnt    (err_cnt),
    .expected   (expected),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one sample, let it be taken at the next edge, then settle.
  task automatic cyc(input logic [3:0] c, input logic e, input logic clr);
    count_in  = c;
    enable    = e;
    clear_err = clr;
    @(posedge clk);
    #1;
    if (mismatch) mm_seen++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; count_in = 4'd0; clear_err = 1'b0;
    #19;
    check("rst_locked", int'(locked), 0);
    check("rst_mismatch", int'(mismatch), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_expected", int'(expected), 0);
    check("rst_wrap", int'(wrap_pulse), 0);
    #1 reset = 1'b0;

    // Clean count locks after 1+4 edges.
    cnt = 4'd0;
    for (int i = 0; i < 4; i++) begin cyc(cnt, 1'b1, 1'b0); cnt++; end
    check("lock_not_yet", int'(locked), 0);
    check("sync_expected", int'(expected), 4);
    cyc(cnt, 1'b1, 1'b0); cnt++;
    check("lock_after5", int'(locked), 1);
    check("lock_no_mm", mm_seen, 0);
    check("lock_err0", int'(err_cnt), 0);

    // Glitch to 9 while 6 is expected.
    cyc(cnt, 1'b1, 1'b0); cnt++;
    check("pre_glitch_expected", int'(expected), 6);
    cyc(4'd9, 1'b1, 1'b0); cnt = 4'd10;
    check("glitch_mm", int'(mismatch), 1);
    check("glitch_err", int'(err_cnt), 1);
    check("glitch_unlock", int'(locked), 0);
    for (int i = 0; i < 3; i++) begin cyc(cnt, 1'b1, 1'b0); cnt++; end
    check("glitch_mm_one_cycle", mm_seen, 1);
    check("relock_not_yet", int'(locked), 0);
    cyc(cnt, 1'b1, 1'b0); cnt++;
    check("relock_after4", int'(locked), 1);

    // Wrap 15 -> 0 while tracking.
    cyc(cnt, 1'b1, 1'b0); cnt++;
    cyc(cnt, 1'b1, 1'b0); cnt++;
    check("pre_wrap_expected", int'(expected), 0);
    cyc(cnt, 1'b1, 1'b0); cnt++;
    check("wrap_no_mm", int'(mismatch), 0);
    check("wrap_pulse", int'(wrap_pulse), WRAP_EXP);
    cyc(cnt, 1'b1, 1'b0); cnt++;
    check("wrap_pulse_one", int'(wrap_pulse), 0);

    // Hold at 3 with enable low.
    cyc(cnt, 1'b1, 1'b0); cnt++;
    for (int i = 0; i < 5; i++) cyc(4'd3, 1'b0, 1'b0);
    check("hold_no_mm", mm_seen, 1);
    check("hold_locked", int'(locked), 1);
    check("hold_expected", int'(expected), 3);
    cyc(4'd4, 1'b0, 1'b0);
    check("adv_dis_mm", int'(mismatch), 1);
    check("adv_dis_err", int'(err_cnt), 2);
    check("adv_dis_unlock", int'(locked), 0);
    cnt = 4'd4;
    for (int i = 0; i < 4; i++) begin cyc(cnt, 1'b1, 1'b0); cnt++; end
    check("relock2", int'(locked), 1);

    // 300 mismatches, each followed by a relock.
    for (int i = 0; i < 300; i++) begin
      cyc(cnt + 4'd5, 1'b1, 1'b0); cnt = cnt + 4'd6;
      for (int j = 0; j < 4; j++) begin cyc(cnt, 1'b1, 1'b0); cnt++; end
      if (i == 9) check("err_after10", int'(err_cnt), 12);
    end
    check("err_saturated", int'(err_cnt), 255);

    // Clear coinciding with a mismatch, then a plain clear.
    cyc(cnt + 4'd5, 1'b1, 1'b1); cnt = cnt + 4'd6;
    check("clr_mm_pulse", int'(mismatch), 1);
    check("clr_mm_err", int'(err_cnt), 1);
    cyc(cnt, 1'b1, 1'b1); cnt++;
    check("clr_only_err", int'(err_cnt), 0);
    for (int i = 0; i < 3; i++) begin cyc(cnt, 1'b1, 1'b0); cnt++; end
    cyc(cnt + 4'd5, 1'b1, 1'b0); cnt = cnt + 4'd6;
    for (int i = 0; i < 4; i++) begin cyc(cnt, 1'b1, 1'b0); cnt++; end
    check("pre_rst_locked", int'(locked), 1);
    check("pre_rst_err", int'(err_cnt), 1);

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1;
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_err", int'(err_cnt), 0);
    check("async_rst_expected", int'(expected), 0);
    #2 reset = 1'b0;
    cnt = 4'd7;
    for (int i = 0; i < 4; i++) begin cyc(cnt, 1'b1, 1'b0); cnt++; end
    check("post_rst_not_yet", int'(locked), 0);
    cyc(cnt, 1'b1, 1'b0); cnt++;
    check("post_rst_locked", int'(locked), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
